// File: rtl/ysyx_041461_pipe_ctrl.sv
// ysyx_041461_pipe_ctrl
// Central hazard and flow controller for the 5-stage core. Drives the
// enable (0 = hold) and flush (load a valid=0 bubble) controls of every
// pipeline register, sequences trap drain/redirect through a small FSM and
// runs a watchdog that flags an EXE register held for too long.
//
// Control contract with the pipeline registers: a register loads on a posedge
// only when its enable is 1; if its flush is also 1 it loads a NOP with
// valid=0 instead of the upstream stage. A flush with enable=0 has no effect
// and is never produced here.
//
// fsm_state and stall_cnt are debug outputs exposing the internal state.
module ysyx_041461_pipe_ctrl #(
  parameter int CNT_W         = 16,
  parameter int STALL_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             EXE_valid,
  input  logic [4:0]       EXE_rd,
  input  logic             EXE_is_load,
  input  logic             EXE_busy,
  input  logic             EXE_redirect,
  input  logic             MEM_busy,
  input  logic             trap_req,
  output logic             IFreg_enable,
  output logic             IDreg_enable,
  output logic             EXEreg_enable,
  output logic             MEMreg_enable,
  output logic             WBreg_enable,
  output logic             IDreg_flush,
  output logic             EXEreg_flush,
  output logic             MEMreg_flush,
  output logic             WBreg_flush,
  output logic             trap_redirect,
  output logic             stall_timeout,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;
  logic [CNT_W-1:0] cnt_next;

  // Load-use detection: a load in EXE whose result the ID instruction reads.
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    rs1_hit  = ID_rs1_used && (ID_rs1 == EXE_rd);
    rs2_hit  = ID_rs2_used && (ID_rs2 == EXE_rd);
    load_use = ID_valid && EXE_valid && EXE_is_load && (EXE_rd != 5'd0) &&
               (rs1_hit || rs2_hit);
  end

  // FSM state register; reset aborts any trap sequence in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pipeline control outputs; everything is low in reset.
  always_comb begin
    state_next    = state;
    IFreg_enable  = 1'b0;
    IDreg_enable  = 1'b0;
    EXEreg_enable = 1'b0;
    MEMreg_enable = 1'b0;
    WBreg_enable  = 1'b0;
    IDreg_flush   = 1'b0;
    EXEreg_flush  = 1'b0;
    MEMreg_flush  = 1'b0;
    WBreg_flush   = 1'b0;
    trap_redirect = 1'b0;
    if (rst) begin
      case (state)
        ST_RUN: begin
          if (trap_req) begin
            // Freeze everything; older instructions finish in DRAIN.
            state_next = ST_DRAIN;
          end else if (MEM_busy) begin
            // Whole pipe waits on memory; nothing moves, nothing is lost.
          end else if (EXE_busy) begin
            // Front end holds, EXE result not ready: bubble into MEM,
            // let WB retire what MEM already has.
            MEMreg_enable = 1'b1;
            MEMreg_flush  = 1'b1;
            WBreg_enable  = 1'b1;
          end else if (EXE_redirect) begin
            // Wrong-path instructions in IF and ID are squashed; the branch
            // itself proceeds to MEM.
            IFreg_enable  = 1'b1;
            IDreg_enable  = 1'b1;
            EXEreg_enable = 1'b1;
            MEMreg_enable = 1'b1;
            WBreg_enable  = 1'b1;
            IDreg_flush   = 1'b1;
            EXEreg_flush  = 1'b1;
          end else if (load_use) begin
            // Hold IF/ID one cycle, bubble behind the load.
            EXEreg_enable = 1'b1;
            EXEreg_flush  = 1'b1;
            MEMreg_enable = 1'b1;
            WBreg_enable  = 1'b1;
          end else begin
            IFreg_enable  = 1'b1;
            IDreg_enable  = 1'b1;
            EXEreg_enable = 1'b1;
            MEMreg_enable = 1'b1;
            WBreg_enable  = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Wait for the outstanding memory access; new traps are ignored.
          if (!MEM_busy) begin
            state_next = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // One cycle: bubble every register and steer PC to the vector.
          IFreg_enable  = 1'b1;
          IDreg_enable  = 1'b1;
          EXEreg_enable = 1'b1;
          MEMreg_enable = 1'b1;
          WBreg_enable  = 1'b1;
          IDreg_flush   = 1'b1;
          EXEreg_flush  = 1'b1;
          MEMreg_flush  = 1'b1;
          WBreg_flush   = 1'b1;
          trap_redirect = 1'b1;
          state_next    = ST_RUN;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  // Watchdog next value: cleared whenever EXE advances, else count and saturate.
  always_comb begin
    cnt_next = stall_cnt;
    if (EXEreg_enable) begin
      cnt_next = '0;
    end else if (stall_cnt != TIMEOUT_VAL) begin
      cnt_next = stall_cnt + 1'b1;
    end
  end

  // Watchdog registers; the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_cnt <= cnt_next;
      if (cnt_next == TIMEOUT_VAL) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Bench for ysyx_041461_pipe_ctrl: table of single-cycle RUN-state vectors
// plus hand-written trap, multi-cycle stall, watchdog and reset sequences.
module tb_ysyx_041461_pipe_ctrl;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             ID_valid, ID_rs1_used, ID_rs2_used;
  logic [4:0]       ID_rs1, ID_rs2, EXE_rd;
  logic             EXE_valid, EXE_is_load, EXE_busy, EXE_redirect;
  logic             MEM_busy, trap_req;
  logic             IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable;
  logic             IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush;
  logic             trap_redirect, stall_timeout;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] stall_cnt;

  ysyx_041461_pipe_ctrl #(.CNT_W(CNT_W), .STALL_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EXE_valid(EXE_valid), .EXE_rd(EXE_rd), .EXE_is_load(EXE_is_load),
    .EXE_busy(EXE_busy), .EXE_redirect(EXE_redirect),
    .MEM_busy(MEM_busy), .trap_req(trap_req),
    .IFreg_enable(IFreg_enable), .IDreg_enable(IDreg_enable),
    .EXEreg_enable(EXEreg_enable), .MEMreg_enable(MEMreg_enable),
    .WBreg_enable(WBreg_enable),
    .IDreg_flush(IDreg_flush), .EXEreg_flush(EXEreg_flush),
    .MEMreg_flush(MEMreg_flush), .WBreg_flush(WBreg_flush),
    .trap_redirect(trap_redirect), .stall_timeout(stall_timeout),
    .fsm_state(fsm_state), .stall_cnt(stall_cnt)
  );

  // {IF,ID,EXE,MEM,WB} enables, {ID,EXE,MEM,WB} flushes, redirect
  logic [9:0] outs;
  assign outs = {IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable,
                 IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush, trap_redirect};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [4:0] en, input logic [3:0] fl,
                          input logic tr);
    chk(name, 32'(outs), 32'({en, fl, tr}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ID_valid = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rs1_used = 0; ID_rs2_used = 0;
    EXE_valid = 0; EXE_rd = 0; EXE_is_load = 0; EXE_busy = 0; EXE_redirect = 0;
    MEM_busy = 0; trap_req = 0;
  endtask

  // inputs change just after the posedge, outputs are sampled at the negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       exe_valid;
    logic [4:0] rd;
    logic       is_load;
    logic       exe_busy;
    logic       redirect;
    logic       mem_busy;
    logic [4:0] en;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic idv, input logic [4:0] r1,
                              input logic [4:0] r2, input logic u1, input logic u2,
                              input logic exv, input logic [4:0] rd, input logic ld,
                              input logic eb, input logic rdr, input logic mb,
                              input logic [4:0] en, input logic [3:0] fl);
    vec_t v;
    v.name = name; v.id_valid = idv; v.rs1 = r1; v.rs2 = r2; v.rs1_used = u1;
    v.rs2_used = u2; v.exe_valid = exv; v.rd = rd; v.is_load = ld; v.exe_busy = eb;
    v.redirect = rdr; v.mem_busy = mb; v.en = en; v.fl = fl;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    //                name          idv r1  r2  u1 u2 exv rd  ld eb rd mb  en        fl
    vecs[0]  = mk("idle",          0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[1]  = mk("lu_rs2",        1, 3,  5,  0, 1, 1,  5,  1, 0, 0, 0, 5'b00111, 4'b0100);
    vecs[2]  = mk("lu_rd_x0",      1, 0,  0,  1, 1, 1,  0,  1, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[3]  = mk("lu_rs1",        1, 7,  2,  1, 0, 1,  7,  1, 0, 0, 0, 5'b00111, 4'b0100);
    vecs[4]  = mk("rs1_unused",    1, 7,  2,  0, 1, 1,  7,  1, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[5]  = mk("not_load",      1, 9,  9,  1, 1, 1,  9,  0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[6]  = mk("exe_invalid",   1, 9,  9,  1, 1, 0,  9,  1, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[7]  = mk("id_invalid",    0, 9,  9,  1, 1, 1,  9,  1, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[8]  = mk("redir_over_lu", 1, 5,  1,  1, 0, 1,  5,  1, 0, 1, 0, 5'b11111, 4'b1100);
    vecs[9]  = mk("busy_over_rdr", 0, 0,  0,  0, 0, 1,  4,  0, 1, 1, 0, 5'b00011, 4'b0010);
    vecs[10] = mk("mem_over_busy", 1, 5,  0,  1, 0, 1,  5,  1, 1, 1, 1, 5'b00000, 4'b0000);
    vecs[11] = mk("redirect",      0, 0,  0,  0, 0, 1,  1,  0, 0, 1, 0, 5'b11111, 4'b1100);
    vecs[12] = mk("rs2_no_use",    1, 4,  6,  1, 0, 1,  6,  1, 0, 0, 0, 5'b11111, 4'b0000);
    for (int i = 0; i < 13; i++) exp_q.push_back({vecs[i].en, vecs[i].fl, 1'b0});

    // ---- reset: everything low even with hazard inputs present ----
    drive_idle();
    EXE_redirect = 1; trap_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset_outs", 5'b00000, 4'b0000, 1'b0);
    chk("reset_state", 32'(fsm_state), 32'(S_RUN));
    chk("reset_cnt", 32'(stall_cnt), 0);
    chk("reset_timeout", 32'(stall_timeout), 0);
    next_cycle();
    drive_idle();
    rst = 1;
    @(negedge clk);
    chk_outs("run_cycle1", 5'b11111, 4'b0000, 1'b0);
    chk("run_cycle1_timeout", 32'(stall_timeout), 0);

    // ---- table of single-cycle RUN vectors ----
    for (int i = 0; i < 13; i++) begin
      logic [9:0] e;
      next_cycle();
      drive_idle();
      ID_valid = vecs[i].id_valid; ID_rs1 = vecs[i].rs1; ID_rs2 = vecs[i].rs2;
      ID_rs1_used = vecs[i].rs1_used; ID_rs2_used = vecs[i].rs2_used;
      EXE_valid = vecs[i].exe_valid; EXE_rd = vecs[i].rd; EXE_is_load = vecs[i].is_load;
      EXE_busy = vecs[i].exe_busy; EXE_redirect = vecs[i].redirect;
      MEM_busy = vecs[i].mem_busy;
      @(negedge clk);
      e = exp_q.pop_front();
      chk(vecs[i].name, 32'(outs), 32'(e));
      chk({vecs[i].name, "_state"}, 32'(fsm_state), 32'(S_RUN));
    end

    // ---- EXE_busy for 3 cycles ----
    next_cycle();
    drive_idle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive_idle();
      EXE_busy = 1;
      @(negedge clk);
      chk_outs($sformatf("exe_busy_%0d", k), 5'b00011, 4'b0010, 1'b0);
      chk($sformatf("exe_busy_cnt_%0d", k), 32'(stall_cnt), k);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk_outs("exe_busy_release", 5'b11111, 4'b0000, 1'b0);
    chk("exe_busy_cnt_3", 32'(stall_cnt), 3);
    next_cycle();
    @(negedge clk);
    chk("exe_busy_cnt_clear", 32'(stall_cnt), 0);
    chk("exe_busy_no_timeout", 32'(stall_timeout), 0);

    // ---- trap with idle memory: redirect at t+2 ----
    next_cycle();
    trap_req = 1;
    @(negedge clk);
    chk_outs("trap0_t", 5'b00000, 4'b0000, 1'b0);
    next_cycle();
    trap_req = 0;
    @(negedge clk);
    chk("trap0_t1_state", 32'(fsm_state), 32'(S_DRAIN));
    chk_outs("trap0_t1", 5'b00000, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("trap0_t2_state", 32'(fsm_state), 32'(S_FLUSH));
    chk_outs("trap0_t2", 5'b11111, 4'b1111, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("trap0_t3_state", 32'(fsm_state), 32'(S_RUN));
    chk_outs("trap0_t3", 5'b11111, 4'b0000, 1'b0);

    // ---- trap with MEM_busy during t+1..t+3; trap_req in DRAIN ignored ----
    next_cycle();
    trap_req = 1;
    @(negedge clk);
    chk_outs("trap1_t", 5'b00000, 4'b0000, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      trap_req = (k == 1);
      MEM_busy = 1;
      @(negedge clk);
      chk($sformatf("trap1_t%0d_state", k), 32'(fsm_state), 32'(S_DRAIN));
      chk_outs($sformatf("trap1_t%0d", k), 5'b00000, 4'b0000, 1'b0);
    end
    chk("trap1_t3_timeout", 32'(stall_timeout), 0);
    next_cycle();
    MEM_busy = 0; trap_req = 0;
    @(negedge clk);
    chk("trap1_t4_state", 32'(fsm_state), 32'(S_DRAIN));
    chk_outs("trap1_t4", 5'b00000, 4'b0000, 1'b0);
    chk("trap1_t4_timeout", 32'(stall_timeout), 1);
    next_cycle();
    @(negedge clk);
    chk("trap1_t5_state", 32'(fsm_state), 32'(S_FLUSH));
    chk_outs("trap1_t5", 5'b11111, 4'b1111, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("trap1_t6_state", 32'(fsm_state), 32'(S_RUN));
    chk_outs("trap1_t6", 5'b11111, 4'b0000, 1'b0);
    chk("trap1_t6_timeout_sticky", 32'(stall_timeout), 1);

    // ---- async reset clears the sticky flag ----
    #2;
    rst = 0;
    #1;
    chk("areset_timeout", 32'(stall_timeout), 0);
    chk_outs("areset_outs", 5'b00000, 4'b0000, 1'b0);
    next_cycle();
    rst = 1;

    // ---- watchdog: MEM_busy held in RUN ----
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      MEM_busy = 1;
      @(negedge clk);
      chk_outs($sformatf("wd_mem_%0d", k), 5'b00000, 4'b0000, 1'b0);
      chk($sformatf("wd_timeout_%0d", k), 32'(stall_timeout), 0);
    end
    next_cycle();
    MEM_busy = 0;
    @(negedge clk);
    chk("wd_tripped", 32'(stall_timeout), 1);
    chk("wd_cnt_sat", 32'(stall_cnt), TIMEOUT);
    chk_outs("wd_resume", 5'b11111, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("wd_sticky", 32'(stall_timeout), 1);
    chk("wd_cnt_clear", 32'(stall_cnt), 0);

    // ---- reset in the middle of DRAIN aborts the trap ----
    next_cycle();
    trap_req = 1;
    @(negedge clk);
    next_cycle();
    trap_req = 0; MEM_busy = 1;
    @(negedge clk);
    chk("mid_drain_state", 32'(fsm_state), 32'(S_DRAIN));
    #1;
    rst = 0;
    #1;
    chk("mid_drain_rst_state", 32'(fsm_state), 32'(S_RUN));
    chk("mid_drain_rst_timeout", 32'(stall_timeout), 0);
    chk_outs("mid_drain_rst_outs", 5'b00000, 4'b0000, 1'b0);
    next_cycle();
    rst = 1; MEM_busy = 0;
    @(negedge clk);
    chk("after_abort_state", 32'(fsm_state), 32'(S_RUN));
    chk_outs("after_abort", 5'b11111, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_outs("after_abort_no_redirect", 5'b11111, 4'b0000, 1'b0);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
Name: ysyx_041461_pipe_ctrl

Overview:
Central pipeline hazard and flow controller for the 5-stage ysyx_041461 core. It drives the enable (hold) and flush (bubble-insert) inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It resolves memory stalls, multi-cycle EXE stalls, load-use hazards, EXE branch redirects and WB trap commits. A small FSM sequences trap drain and redirect, and a watchdog counter flags runaway stalls.

Parameters:
CNT_W, 16, width of the stall watchdog counter
STALL_TIMEOUT, 1000, consecutive EXE-hold cycles before stall_timeout asserts; must be < 2^CNT_W

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
ID_valid  in  1  ID stage holds a valid instruction
ID_rs1  in  5  ID source register 1
ID_rs2  in  5  ID source register 2
ID_rs1_used  in  1  ID instruction reads rs1
ID_rs2_used  in  1  ID instruction reads rs2
EXE_valid  in  1  EXE stage holds a valid instruction
EXE_rd  in  5  EXE destination register
EXE_is_load  in  1  EXE instruction is a load
EXE_busy  in  1  multi-cycle mul/div in EXE not finished
EXE_redirect  in  1  taken branch/jump resolved in EXE
MEM_busy  in  1  memory access outstanding in MEM
trap_req  in  1  WB commits an instruction with a trap
IFreg_enable / IDreg_enable / EXEreg_enable / MEMreg_enable / WBreg_enable  out  1 each  register load enable; 0 = hold
IDreg_flush / EXEreg_flush / MEMreg_flush / WBreg_flush  out  1 each  when 1 with enable=1, register loads a NOP with valid=0
trap_redirect  out  1  PC selects the trap vector this cycle
stall_timeout  out  1  watchdog tripped (sticky until reset)

Behaviour:
- Reset (rst=0, asynchronous): FSM=RUN, stall_cnt=0, stall_timeout=0. While rst=0, all enables=0, all flushes=0, trap_redirect=0.
- Combinational outputs are derived from FSM state and the current inputs. The only registers are the FSM, stall_cnt and stall_timeout.
- load_use = ID_valid & EXE_valid & EXE_is_load & EXE_rd!=0 & ((ID_rs1_used & ID_rs1==EXE_rd) | (ID_rs2_used & ID_rs2==EXE_rd)).
- FSM states: RUN, DRAIN, FLUSH.
- RUN, priority highest first:
  1. trap_req: all enables=0. Next state DRAIN.
  2. MEM_busy: all enables=0, no flush.
  3. EXE_busy: IF/ID/EXE enables=0. MEMreg_enable=1 with MEMreg_flush=1. WBreg_enable=1.
  4. EXE_redirect: all enables=1, IDreg_flush=1, EXEreg_flush=1.
  5. load_use: IF/ID enables=0. EXEreg_enable=1 with EXEreg_flush=1. MEM/WB enables=1.
  6. Otherwise: all enables=1, no flush.
- DRAIN: all enables=0. Stay while MEM_busy=1. Go to FLUSH when MEM_busy=0. trap_req is ignored here.
- FLUSH (exactly 1 cycle): all enables=1, all four flushes=1, trap_redirect=1. Next state RUN.
- Trap latency: trap_req at cycle t with MEM_busy=0 gives trap_redirect at t+2.
- A reset asserted in DRAIN or FLUSH aborts the sequence: FSM=RUN, no redirect is issued.
- Watchdog, evaluated each posedge:
  - EXEreg_enable=1: stall_cnt<=0.
  - Else: stall_cnt<=stall_cnt+1, saturating at STALL_TIMEOUT.
  - stall_timeout<=1 when the next stall_cnt equals STALL_TIMEOUT; it stays 1 until reset.
- EXE_rd=0 never causes a load-use stall (x0).

Test Plan:
- Reset, then rst=1, no hazard inputs: cycle 1 all enables=1, all flushes=0, trap_redirect=0, stall_timeout=0.
- EXE_valid=1, EXE_is_load=1, EXE_rd=5; ID_valid=1, ID_rs2_used=1, ID_rs2=5 → IF/ID enable=0, EXEreg_enable=1, EXEreg_flush=1. Repeat with EXE_rd=0 → no stall.
- EXE_redirect=1 together with load_use=1 → all enables=1, IDreg_flush=EXEreg_flush=1; redirect wins.
- EXE_busy=1 for 3 cycles → IF/ID/EXE held for 3 cycles, MEMreg_flush=1 each cycle, stall_cnt=3, then 0 once EXE_busy=0.
- trap_req pulse at t, MEM_busy=1 during t+1..t+3 → DRAIN holds all stages; FLUSH at t+5 with all flushes=1 and trap_redirect=1 for exactly 1 cycle; RUN at t+6.
- STALL_TIMEOUT=4, MEM_busy held high → stall_timeout=1 after the 4th posedge and stays 1 after MEM_busy drops; rst=0 mid-DRAIN → FSM RUN, stall_timeout=0.
